// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Sized for the widest legal operand so any WIDTH instance can use them.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int MAX_WIDTH = 32;
  // Step counter never exceeds WIDTH-1, so the widest legal width bounds it.
  localparam int CNT_W = $clog2(MAX_WIDTH);

  // Magnitude of a width-bit operand; -2^(width-1) maps to 2^(width-1).
  function automatic logic [MAX_WIDTH-1:0] abs_w(input logic [MAX_WIDTH-1:0] value,
                                                 input int width,
                                                 input logic is_signed);
    logic [MAX_WIDTH-1:0] mask;
    mask = (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
    if (is_signed && value[width-1])
      return (~value + MAX_WIDTH'(1)) & mask;
    return value & mask;
  endfunction

endpackage

// File: rtl/mul_add_step.sv
// One shift-add iteration: conditional WIDTH+1-bit add into the upper half
// of the accumulator, then a right shift of {carry, accumulator}.
module mul_add_step #(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
  input  logic               add_en,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (add_en ? {1'b0, mcand} : '0);
  // The bit shifted out of the low end is consumed and discarded here.
  assign acc_next = (2*WIDTH)'({sum, acc[WIDTH-1:0]} >> 1);

endmodule

// File: rtl/seq_multiplier.sv
// Handshaked sequential shift-add multiplier, unsigned or two's complement
// per transaction, fixed latency of WIDTH cycles from accept to out_valid.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y,
  output logic               busy
);

  state_t             state, state_next;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0]   mcand, mplier;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic               accept, last_step;

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign last_step = (state == CALC) && (cnt == CNT_W'(WIDTH - 1));
  assign busy      = (state == CALC);

  mul_add_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .add_en   (mplier[0]),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = in_valid ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands are stored as magnitudes; the sign is reapplied once at the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        mcand  <= WIDTH'(abs_w(MAX_WIDTH'(a), WIDTH, signed_mode));
        mplier <= WIDTH'(abs_w(MAX_WIDTH'(b), WIDTH, signed_mode));
        neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        acc    <= '0;
        cnt    <= '0;
      end else if (state == CALC) begin
        acc    <= acc_next;
        mplier <= mplier >> 1;
        cnt    <= cnt + CNT_W'(1);
        if (last_step)
          y <= neg ? -acc_next : acc_next;
      end

      if (last_step)
        out_valid <= 1'b1;
      else if (state == DONE && out_ready)
        out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH 4, 8 and 16: directed
// table, backpressure and reset sequences, then randomized traffic.
module tb_seq_multiplier;

  localparam int NRAND = 300;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  iv, ordy;
  logic [2:0]  ir, ov, bsy;
  logic        smode;
  logic [15:0] a_in, b_in;
  logic [7:0]  y4;
  logic [15:0] y8;
  logic [31:0] y16;

  int          sel;
  logic        cur_ready, cur_valid, cur_busy;
  logic [31:0] cur_y;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_in[3:0]), .b(b_in[3:0]), .signed_mode(smode),
    .out_valid(ov[0]), .out_ready(ordy[0]), .y(y4), .busy(bsy[0])
  );

  seq_multiplier #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_in[7:0]), .b(b_in[7:0]), .signed_mode(smode),
    .out_valid(ov[1]), .out_ready(ordy[1]), .y(y8), .busy(bsy[1])
  );

  seq_multiplier #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_in), .b(b_in), .signed_mode(smode),
    .out_valid(ov[2]), .out_ready(ordy[2]), .y(y16), .busy(bsy[2])
  );

  always_comb begin
    cur_ready = ir[sel];
    cur_valid = ov[sel];
    cur_busy  = bsy[sel];
    case (sel)
      0:       cur_y = {24'b0, y4};
      1:       cur_y = {16'b0, y8};
      default: cur_y = y16;
    endcase
  end

  typedef struct {
    int          sel;
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic [31:0] expected;
  } vec_t;

  vec_t vecs[10];

  // Reference: interpret operands as integers, multiply, wrap to 2*w bits.
  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic sm);
    longint m, sa, sb, p;
    m  = (longint'(1) << w) - 1;
    sa = longint'(a) & m;
    sb = longint'(b) & m;
    if (sm && ((sa >> (w - 1)) & 1) == 1) sa = sa - (longint'(1) << w);
    if (sm && ((sb >> (w - 1)) & 1) == 1) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Holds in_valid until the selected DUT takes the operands (bounded).
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic s);
    bit taken;
    taken = 1'b0;
    a_in = a;
    b_in = b;
    smode = s;
    iv[sel] = 1'b1;
    for (int n = 0; n < 200 && !taken; n++) begin
      #1;
      taken = cur_ready;
      tick();
    end
    iv[sel] = 1'b0;
    if (!taken) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  // Waits for out_valid, optionally stalls, then completes the handshake.
  task automatic collect(output logic [31:0] yv, output int lat, input int hold);
    lat = 0;
    while (!cur_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!cur_valid) checkOutput("result_timeout", 32'd0, 32'd1);
    repeat (hold) tick();
    yv = cur_y;
    ordy[sel] = 1'b1;
    tick();
    ordy[sel] = 1'b0;
  endtask

  initial begin
    logic [31:0] yv;
    logic [15:0] ra, rb, mask;
    int          lat, w;
    bit          stable;

    vecs[0] = '{0, 16'h000F, 16'h000F, 1'b0, 32'h0000_00E1};
    vecs[1] = '{0, 16'h0008, 16'h0008, 1'b1, 32'h0000_0040};
    vecs[2] = '{0, 16'h0008, 16'h0007, 1'b1, 32'h0000_00C8};
    vecs[3] = '{1, 16'h0000, 16'h00FF, 1'b0, 32'h0000_0000};
    vecs[4] = '{1, 16'h00FF, 16'h0080, 1'b1, 32'h0000_0080};
    vecs[5] = '{1, 16'h0007, 16'h0009, 1'b0, 32'h0000_003F};
    vecs[6] = '{1, 16'h0080, 16'h0080, 1'b1, 32'h0000_4000};
    vecs[7] = '{1, 16'h007F, 16'h0080, 1'b1, 32'h0000_C080};
    vecs[8] = '{2, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000};
    vecs[9] = '{2, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001};

    iv = '0; ordy = '0; smode = 1'b0; a_in = '0; b_in = '0; sel = 0;
    rst_n = 1'b0;
    #2;
    checkOutput("rst_in_ready", {29'b0, ir}, 32'h7);
    checkOutput("rst_out_valid", {29'b0, ov}, 32'h0);
    checkOutput("rst_busy", {29'b0, bsy}, 32'h0);
    checkOutput("rst_y4", {24'b0, y4}, 32'h0);
    checkOutput("rst_y8", {16'b0, y8}, 32'h0);
    checkOutput("rst_y16", y16, 32'h0);
    #10;
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      sel = vecs[i].sel;
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sm);
      collect(yv, lat, 0);
      checkOutput($sformatf("vec%0d_y", i), yv, vecs[i].expected);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(4 << sel));
    end

    // Backpressure on the 8-bit instance, then a same-edge drain and accept.
    sel = 1;
    applyStimulus(16'd13, 16'd11, 1'b0);
    lat = 0;
    while (!cur_valid && lat < 100) begin
      tick();
      lat++;
    end
    yv = cur_y;
    checkOutput("bp_first_y", yv, 32'd143);
    stable = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (cur_y !== yv || cur_valid !== 1'b1 || cur_ready !== 1'b0) stable = 1'b0;
    end
    checkOutput("bp_hold_stable", {31'b0, stable}, 32'd1);
    a_in = 16'd25;
    b_in = 16'h00FD;
    smode = 1'b1;
    iv[1] = 1'b1;
    ordy[1] = 1'b1;
    #1;
    checkOutput("bp_ready_with_out_ready", {31'b0, cur_ready}, 32'd1);
    tick();
    iv[1] = 1'b0;
    ordy[1] = 1'b0;
    checkOutput("bp_out_valid_drop", {31'b0, cur_valid}, 32'd0);
    checkOutput("bp_busy_after_accept", {31'b0, cur_busy}, 32'd1);
    collect(yv, lat, 0);
    checkOutput("bp_second_y", yv, 32'h0000_FFB5);
    checkOutput("bp_second_latency", 32'(lat), 32'd8);

    // Reset in the middle of a calculation.
    sel = 1;
    applyStimulus(16'd200, 16'd200, 1'b0);
    tick();
    tick();
    checkOutput("mid_busy_before_reset", {31'b0, cur_busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", {31'b0, cur_valid}, 32'd0);
    checkOutput("mid_rst_in_ready", {31'b0, cur_ready}, 32'd1);
    checkOutput("mid_rst_busy", {31'b0, cur_busy}, 32'd0);
    #1;
    rst_n = 1'b1;
    applyStimulus(16'd7, 16'd9, 1'b0);
    collect(yv, lat, 0);
    checkOutput("post_rst_y", yv, 32'd63);
    checkOutput("post_rst_latency", 32'(lat), 32'd8);

    // Randomized traffic with idle gaps and consumer stalls.
    for (int s = 1; s <= 2; s++) begin
      sel = s;
      w = 4 << s;
      mask = 16'((32'd1 << w) - 32'd1);
      for (int m = 0; m < 2; m++) begin
        for (int t = 0; t < NRAND; t++) begin
          ra = 16'($urandom) & mask;
          rb = 16'($urandom) & mask;
          repeat ($urandom_range(0, 3)) tick();
          applyStimulus(ra, rb, m[0]);
          collect(yv, lat, int'($urandom_range(0, 3)));
          checkOutput($sformatf("rand_w%0d_s%0d_%0h_x_%0h", w, m, ra, rb),
                      yv, ref_mul(w, ra, rb, m[0]));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
